// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver. Oversampled start-bit qualification, mid-bit
//               data sampling, optional parity, 1/2 stop bits, break detect.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_Rx_ClkTick,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Rx_Valid,
    output logic                 o_Rx_Parity_Err,
    output logic                 o_Rx_Frame_Err,
    output logic                 o_Rx_Busy
);

    localparam int c_TICK_W = $clog2(RX_OVERSAMPLE);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [c_TICK_W-1:0] c_CNT_MAX   = c_TICK_W'(RX_OVERSAMPLE - 1);
    localparam logic [c_TICK_W-1:0] c_CNT_HALF  = c_TICK_W'(RX_OVERSAMPLE / 2 - 1);
    localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                 state_q;
    logic [1:0]             sync_q;
    logic                   tick_prev_q;
    logic [c_TICK_W-1:0]    tick_cnt_q;
    logic [c_BIT_W-1:0]     bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_err_q;
    logic                   frm_err_q;

    logic                   rx_s;
    logic                   tick;
    logic                   cnt_at_max;
    logic [c_TICK_W-1:0]    tick_cnt_inc;

    assign rx_s         = sync_q[1];
    assign tick         = i_Rx_ClkTick & ~tick_prev_q;
    assign cnt_at_max   = (tick_cnt_q == c_CNT_MAX);
    assign tick_cnt_inc = cnt_at_max ? '0 : tick_cnt_q + c_TICK_W'(1);

    // The tick history keeps tracking through reset so an edge that lands
    // during reset is consumed rather than replayed afterwards.
    always_ff @(posedge clk) begin
        tick_prev_q <= i_Rx_ClkTick;
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_Rx_Serial};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            tick_cnt_q      <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            par_err_q       <= 1'b0;
            frm_err_q       <= 1'b0;
            o_Rx_Data       <= '0;
            o_Rx_Valid      <= 1'b0;
            o_Rx_Parity_Err <= 1'b0;
            o_Rx_Frame_Err  <= 1'b0;
            o_Rx_Busy       <= 1'b0;
        end else begin
            o_Rx_Valid <= 1'b0;
            if (tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (!rx_s) begin
                            state_q    <= S_START;
                            tick_cnt_q <= '0;
                            o_Rx_Busy  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (tick_cnt_q == c_CNT_HALF) begin
                            tick_cnt_q <= '0;
                            if (!rx_s) begin
                                state_q   <= S_DATA;
                                bit_cnt_q <= '0;
                                par_err_q <= 1'b0;
                                frm_err_q <= 1'b0;
                            end else begin
                                state_q   <= S_IDLE;
                                o_Rx_Busy <= 1'b0;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_inc;
                        end
                    end
                    S_DATA: begin
                        tick_cnt_q <= tick_cnt_inc;
                        if (cnt_at_max) begin
                            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                            if (bit_cnt_q == c_DATA_LAST) begin
                                bit_cnt_q <= '0;
                                state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + c_BIT_W'(1);
                            end
                        end
                    end
                    S_PARITY: begin
                        tick_cnt_q <= tick_cnt_inc;
                        if (cnt_at_max) begin
                            // Odd mode flags an even overall count, even mode an odd one.
                            par_err_q <= (^shift_q) ^ rx_s ^ (PARITY == 1);
                            state_q   <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        tick_cnt_q <= tick_cnt_inc;
                        if (cnt_at_max) begin
                            if (bit_cnt_q == c_STOP_LAST) begin
                                o_Rx_Data       <= shift_q;
                                o_Rx_Parity_Err <= par_err_q;
                                o_Rx_Frame_Err  <= frm_err_q | ~rx_s;
                                o_Rx_Valid      <= 1'b1;
                                if (rx_s) begin
                                    state_q   <= S_IDLE;
                                    o_Rx_Busy <= 1'b0;
                                end else begin
                                    state_q <= S_BREAK;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + c_BIT_W'(1);
                                frm_err_q <= frm_err_q | ~rx_s;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (rx_s) begin
                            state_q   <= S_IDLE;
                            o_Rx_Busy <= 1'b0;
                        end
                    end
                    default: begin
                        state_q   <= S_IDLE;
                        o_Rx_Busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (8N1 and 8E2 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [1:0] stop;      // [0] = first stop bit on the line
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic rx_tick = 1'b0;
    logic line0   = 1'b1;
    logic line1   = 1'b1;

    logic [7:0] data0, data1;
    logic       v0, v1, pe0, pe1, fe0, fe1, b0, b1;

    rec_t act0[$];
    rec_t act1[$];
    rec_t exp0[$];
    vec_t tbl[8];

    int total = 0;
    int bad   = 0;
    int busy_cycles0 = 0;

    uart_rx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .RX_OVERSAMPLE(OS)) dut0 (
        .clk(clk), .reset(reset), .i_Rx_ClkTick(rx_tick), .i_Rx_Serial(line0),
        .o_Rx_Data(data0), .o_Rx_Valid(v0), .o_Rx_Parity_Err(pe0),
        .o_Rx_Frame_Err(fe0), .o_Rx_Busy(b0)
    );

    uart_rx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .RX_OVERSAMPLE(OS)) dut1 (
        .clk(clk), .reset(reset), .i_Rx_ClkTick(rx_tick), .i_Rx_Serial(line1),
        .o_Rx_Data(data1), .o_Rx_Valid(v1), .o_Rx_Parity_Err(pe1),
        .o_Rx_Frame_Err(fe1), .o_Rx_Busy(b1)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (2) @(negedge clk);
            rx_tick = ~rx_tick;
        end
    end

    always @(negedge clk) begin
        if (v0) act0.push_back({data0, pe0, fe0});
        if (v1) act1.push_back({data1, pe1, fe1});
        if (b0) busy_cycles0++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge rx_tick);
    endtask

    task automatic drive(input int sel, input logic b);
        if (sel == 0) line0 = b;
        else          line1 = b;
    endtask

    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drive(sel, bits[i]);
            wait_ticks(OS);
        end
    endtask

    task automatic send8n1(input logic [7:0] d, input logic stop, input int gap_bits);
        send_bits(0, {6'b0, stop, d, 1'b0}, 10);
        line0 = 1'b1;
        wait_ticks(gap_bits * OS);
    endtask

    // Reference: 8N1 frame yields its data bits, never a parity error,
    // and a framing error exactly when the stop bit is low.
    function automatic rec_t model_8n1(input logic [7:0] d, input logic stop);
        rec_t r;
        r.data = d;
        r.perr = 1'b0;
        r.ferr = ~stop;
        return r;
    endfunction

    task automatic drain0(input string name);
        rec_t e;
        rec_t a;
        while (exp0.size() > 0) begin
            e = exp0.pop_front();
            if (act0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s: no valid seen, expected data %0h", name, e.data);
            end else begin
                a = act0.pop_front();
                check({name, " data"}, a.data, e.data);
                check({name, " perr"}, a.perr, e.perr);
                check({name, " ferr"}, a.ferr, e.ferr);
            end
        end
        check({name, " extra valids"}, act0.size(), 0);
        act0.delete();
    endtask

    rec_t       a1;
    logic [7:0] d_r;
    logic       s_r;
    int         g_r;
    int         bc;
    logic [7:0] dsave;

    initial begin
        tbl[0] = '{8'h07, 1'b0, 2'b11, 8'h07, 1'b1, 1'b0};
        tbl[1] = '{8'h07, 1'b1, 2'b11, 8'h07, 1'b0, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 1'b0, 2'b11, 8'h80, 1'b1, 1'b0};
        tbl[5] = '{8'h3C, 1'b0, 2'b10, 8'h3C, 1'b0, 1'b1};
        tbl[6] = '{8'h3C, 1'b0, 2'b01, 8'h3C, 1'b0, 1'b1};
        tbl[7] = '{8'h5A, 1'b1, 2'b11, 8'h5A, 1'b1, 1'b0};

        // Reset state
        repeat (4) @(negedge clk);
        check("reset data", data0, 0);
        check("reset valid", v0, 0);
        check("reset perr", pe0, 0);
        check("reset ferr", fe0, 0);
        check("reset busy", b0, 0);
        reset = 1'b0;
        wait_ticks(OS);

        // Clean frame
        exp0.push_back(model_8n1(8'hA5, 1'b1));
        send8n1(8'hA5, 1'b1, 2);
        drain0("clean");
        check("clean busy after", b0, 0);

        // Glitch rejection
        bc    = busy_cycles0;
        dsave = data0;
        line0 = 1'b0;
        wait_ticks(4);
        line0 = 1'b1;
        wait_ticks(2 * OS);
        check("glitch busy pulsed", busy_cycles0 > bc, 1);
        check("glitch busy idle", b0, 0);
        check("glitch data held", data0, dsave);
        drain0("glitch");

        // Break: stop bit low, then line held low
        exp0.push_back(model_8n1(8'h3C, 1'b0));
        send_bits(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
        wait_ticks(64);
        check("break busy held", b0, 1);
        drain0("break");
        line0 = 1'b1;
        wait_ticks(2 * OS);
        check("break released busy", b0, 0);
        exp0.push_back(model_8n1(8'h55, 1'b1));
        send8n1(8'h55, 1'b1, 2);
        drain0("after break");

        // Reset in the middle of data bit 4 of 0xFF
        send_bits(0, 16'b0000_0000_0001_1110, 5);
        line0 = 1'b1;
        wait_ticks(OS / 2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset data", data0, 0);
        check("midreset busy", b0, 0);
        check("midreset ferr", fe0, 0);
        wait_ticks(6 * OS);
        exp0.push_back(model_8n1(8'h12, 1'b1));
        send8n1(8'h12, 1'b1, 2);
        drain0("midreset next");

        // Back-to-back frames with no idle gap
        exp0.push_back(model_8n1(8'h01, 1'b1));
        exp0.push_back(model_8n1(8'h80, 1'b1));
        exp0.push_back(model_8n1(8'hFF, 1'b1));
        send8n1(8'h01, 1'b1, 0);
        send8n1(8'h80, 1'b1, 0);
        send8n1(8'hFF, 1'b1, 2);
        drain0("b2b");

        // Table-driven even-parity, two-stop-bit frames
        for (int i = 0; i < 8; i++) begin
            send_bits(1, {4'b0, tbl[i].stop[1], tbl[i].stop[0], tbl[i].par, tbl[i].data, 1'b0}, 12);
            line1 = 1'b1;
            wait_ticks(2 * OS);
            if (act1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tbl%0d: no valid seen, expected data %0h", i, tbl[i].exp_data);
            end else begin
                a1 = act1.pop_front();
                check($sformatf("tbl%0d data", i), a1.data, tbl[i].exp_data);
                check($sformatf("tbl%0d perr", i), a1.perr, tbl[i].exp_perr);
                check($sformatf("tbl%0d ferr", i), a1.ferr, tbl[i].exp_ferr);
            end
        end
        check("tbl extra valids", act1.size(), 0);

        // Randomised 8N1 traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            d_r = 8'($urandom);
            s_r = ($urandom_range(0, 4) != 0);
            g_r = s_r ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            exp0.push_back(model_8n1(d_r, s_r));
            send8n1(d_r, s_r, g_r);
        end
        wait_ticks(2 * OS);
        drain0("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
